// File: rtl/sm2_kdf_ctrl_if.sv
// SM3 two-block hash core bus: 512-bit data plus 32-bit counter in, 256-bit digest out.
// The KDF controller drives it as master; the hash core is the slave.
interface sm2_kdf_ctrl_if;
  logic [511:0] sm3_datain;
  logic [31:0]  sm3_appendin;
  logic         sm3_start;
  logic [255:0] sm3_hashout;
  logic         sm3_valid;

  modport master (
    output sm3_datain,
    output sm3_appendin,
    output sm3_start,
    input  sm3_hashout,
    input  sm3_valid
  );

  modport slave (
    input  sm3_datain,
    input  sm3_appendin,
    input  sm3_start,
    output sm3_hashout,
    output sm3_valid
  );
endinterface

// File: rtl/sm2_kdf_ctrl.sv
// SM2 KDF controller: hashes x2||y2||ct for ct = 1..NBLK on an SM3 core and presents the
// leftmost KLEN bits of Ha_1||Ha_2||... as the derived key, flagging the all-zero key.
module sm2_kdf_ctrl #(
  parameter int unsigned KLEN = 256
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [511:0]        xy_in,
  input  logic                start,
  output logic                busy,
  output logic [KLEN-1:0]     key_out,
  output logic                key_zero,
  output logic                valid,
  sm2_kdf_ctrl_if.master      sm3
);

  localparam int unsigned NBLK = (KLEN + 255) / 256;
  localparam int unsigned BUFW = NBLK * 256;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     ct_q, ct_d;
  logic [511:0]    xy_q, xy_d;
  logic [BUFW-1:0] buf_q, buf_d;
  logic            kz_q, kz_d;

  logic accept;
  logic capture;
  logic last;

  assign accept  = (state_q == StIdle) && start;
  assign capture = (state_q == StWait) && sm3.sm3_valid;
  assign last    = (ct_q == 32'(NBLK));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (sm3.sm3_valid) state_d = last ? StDone : StIssue;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy          = (state_q != StIdle);
    valid         = (state_q == StDone);
    sm3.sm3_start = (state_q == StIssue);
  end

  // Datapath next-state: latch on accept, capture one digest slice per returned hash.
  always_comb begin
    xy_d  = xy_q;
    ct_d  = ct_q;
    buf_d = buf_q;
    kz_d  = kz_q;
    if (accept) begin
      xy_d  = xy_in;
      ct_d  = 32'd1;
      buf_d = '0;
      kz_d  = 1'b0;
    end
    if (capture) begin
      for (int unsigned i = 0; i < NBLK; i++) begin
        if (ct_q == 32'(i + 1)) begin
          buf_d[(NBLK - i) * 256 - 1 -: 256] = sm3.sm3_hashout;
        end
      end
      if (last) begin
        kz_d = ~|buf_d[BUFW-1 -: KLEN];
      end else begin
        ct_d = ct_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xy_q  <= '0;
      ct_q  <= '0;
      buf_q <= '0;
      kz_q  <= 1'b0;
    end else begin
      xy_q  <= xy_d;
      ct_q  <= ct_d;
      buf_q <= buf_d;
      kz_q  <= kz_d;
    end
  end

  // Truncation drops the low bits of the last digest when KLEN is not a multiple of 256.
  assign key_out          = buf_q[BUFW-1 -: KLEN];
  assign key_zero         = kz_q;
  assign sm3.sm3_datain   = xy_q;
  assign sm3.sm3_appendin = ct_q;

endmodule
